// File: rtl/os_mac_pe.sv
// Output-stationary MAC processing element with valid/last tile framing,
// signed/unsigned operands, fixed-point scaling and saturating accumulation.
module os_mac_pe #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 0,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+4,
  parameter int OUT_WIDTH  = 2*DATA_WIDTH,
  parameter bit SIGNED     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic                  i_last,
  input  logic [DATA_WIDTH-1:0] i_up,
  input  logic [DATA_WIDTH-1:0] i_left,
  output logic [DATA_WIDTH-1:0] o_down,
  output logic [DATA_WIDTH-1:0] o_right,
  output logic                  o_valid,
  output logic                  o_last,
  output logic [OUT_WIDTH-1:0]  o_result,
  output logic                  o_result_valid,
  output logic                  o_ovf
);

  localparam int XW = 2*DATA_WIDTH+2;
  localparam int SW = (ACC_WIDTH > XW ? ACC_WIDTH : XW) + 1;
  localparam int EW = ACC_WIDTH + 2;

  // Clamp bounds, all held in a common signed width wide enough for acc+prod
  localparam logic signed [EW-1:0] ACC_MAX = SIGNED ?
    EW'({1'b0, {(ACC_WIDTH-1){1'b1}}}) : EW'({ACC_WIDTH{1'b1}});
  localparam logic signed [EW-1:0] ACC_MIN = SIGNED ? ~ACC_MAX : '0;
  localparam logic signed [EW-1:0] OUT_MAX = SIGNED ?
    EW'({(OUT_WIDTH-1){1'b1}}) : EW'({OUT_WIDTH{1'b1}});
  localparam logic signed [EW-1:0] OUT_MIN = SIGNED ? ~OUT_MAX : '0;

  typedef enum logic {IDLE, ACCUM} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] down_q, down_d;
  logic [DATA_WIDTH-1:0] right_q, right_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                  ovf_q, ovf_d;
  logic [OUT_WIDTH-1:0]  res_q, res_d;
  logic                  rv_q, rv_d;
  logic                  rovf_q, rovf_d;

  logic signed [SW-1:0] up_x, left_x, prod_x;
  logic [ACC_WIDTH-1:0] prod;
  logic signed [EW-1:0] acc_e, prod_e, sum_e, sum_c;
  logic signed [EW-1:0] accn_e, out_c;
  logic                 unused_ok;

  always_comb begin
    up_x   = SIGNED ? SW'($signed(i_up))   : SW'(i_up);
    left_x = SIGNED ? SW'($signed(i_left)) : SW'(i_left);
    prod_x = (up_x * left_x) >>> FRAC_BITS;
    prod   = prod_x[ACC_WIDTH-1:0];
    acc_e  = SIGNED ? EW'($signed(acc_q)) : EW'(acc_q);
    prod_e = SIGNED ? EW'($signed(prod))  : EW'(prod);
    sum_e  = acc_e + prod_e;
    if (sum_e > ACC_MAX)      sum_c = ACC_MAX;
    else if (sum_e < ACC_MIN) sum_c = ACC_MIN;
    else                      sum_c = sum_e;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    res_d   = res_q;
    rovf_d  = rovf_q;
    rv_d    = 1'b0;
    valid_d = i_valid;
    last_d  = i_valid & i_last;
    down_d  = i_valid ? i_up : down_q;
    right_d = i_valid ? i_left : right_q;
    if (i_valid) begin
      unique case (state_q)
        IDLE: begin
          acc_d = prod;
          ovf_d = 1'b0;
        end
        ACCUM: begin
          acc_d = sum_c[ACC_WIDTH-1:0];
          ovf_d = ovf_q | (sum_c != sum_e);
        end
        default: ;
      endcase
      state_d = i_last ? IDLE : ACCUM;
    end
    accn_e = SIGNED ? EW'($signed(acc_d)) : EW'(acc_d);
    if (accn_e > OUT_MAX)      out_c = OUT_MAX;
    else if (accn_e < OUT_MIN) out_c = OUT_MIN;
    else                       out_c = accn_e;
    if (i_valid && i_last) begin
      rv_d   = 1'b1;
      res_d  = out_c[OUT_WIDTH-1:0];
      rovf_d = ovf_d | (out_c != accn_e);
    end
  end

  assign unused_ok = ^{prod_x[SW-1:ACC_WIDTH],
                       sum_c[EW-1:ACC_WIDTH],
                       out_c[EW-1:OUT_WIDTH]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      down_q  <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
      rv_q    <= 1'b0;
      rovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      down_q  <= down_d;
      right_q <= right_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
      rv_q    <= rv_d;
      rovf_q  <= rovf_d;
    end
  end

  assign o_down         = down_q;
  assign o_right        = right_q;
  assign o_valid        = valid_q;
  assign o_last         = last_q;
  assign o_result       = res_q;
  assign o_result_valid = rv_q;
  assign o_ovf          = rovf_q;

endmodule
